// File: rtl/tour_cmd_seq.sv
// tour_cmd_seq: replays the solver's one-hot moves as vertical and horizontal motion commands.
// Outside a tour it passes UART commands straight through to the command processor.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start_tour          solver done pulse; starts a replay from move 0
//   move / mv_indx      solver read port (one-hot move at index mv_indx)
//   cmd_UART, cmd_rdy_UART, clr_cmd_rdy_UART   UART wrapper side
//   cmd, cmd_rdy, clr_cmd_rdy, send_resp       command processor side
//   resp                response byte for the UART transmitter
//   tour_busy           high while a tour is being replayed
//
// Build option: define TOUR_FANFARE_EN to issue horizontal legs with the fanfare opcode.
module tour_cmd_seq #(
    parameter int NUM_MOVES = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_tour,
    input  logic [7:0]  move,
    output logic [4:0]  mv_indx,
    input  logic [15:0] cmd_UART,
    input  logic        cmd_rdy_UART,
    output logic        clr_cmd_rdy_UART,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    output logic [7:0]  resp,
    output logic        tour_busy
);

    localparam logic [4:0] LAST = 5'(NUM_MOVES - 1);

    localparam logic [3:0] OP_MOVE = 4'b0010;
`ifdef TOUR_FANFARE_EN
    localparam logic [3:0] OP_HORZ = 4'b0011;
`else
    localparam logic [3:0] OP_HORZ = 4'b0010;
`endif

    localparam logic [7:0] NORTH = 8'h00;
    localparam logic [7:0] WEST  = 8'h3F;
    localparam logic [7:0] SOUTH = 8'h7F;
    localparam logic [7:0] EAST  = 8'hBF;

    typedef enum logic [2:0] {
        IDLE,
        VERT,
        HOLDV,
        HORZ,
        HOLDH
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [4:0] indx_nxt;

    logic [7:0] v_head;
    logic [3:0] v_sq;
    logic [7:0] h_head;
    logic [3:0] h_sq;

    logic       last_move;

    assign last_move = (mv_indx == LAST);

    // State and index registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            mv_indx <= '0;
        end else begin
            state   <= state_nxt;
            mv_indx <= indx_nxt;
        end
    end

    // Next-state logic; handshake strobes outside their state are ignored
    always_comb begin
        state_nxt = state;
        indx_nxt  = mv_indx;
        case (state)
            IDLE: begin
                if (start_tour) begin
                    state_nxt = VERT;
                    indx_nxt  = '0;
                end
            end
            VERT: begin
                if (clr_cmd_rdy) state_nxt = HOLDV;
            end
            HOLDV: begin
                if (send_resp) state_nxt = HORZ;
            end
            HORZ: begin
                if (clr_cmd_rdy) state_nxt = HOLDH;
            end
            HOLDH: begin
                if (send_resp) begin
                    if (last_move) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = VERT;
                        indx_nxt  = mv_indx + 5'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Move decode; anything not one-hot gives zero-square legs
    always_comb begin
        v_head = NORTH;
        v_sq   = 4'd0;
        h_head = NORTH;
        h_sq   = 4'd0;
        case (move)
            8'h01: begin v_head = NORTH; v_sq = 4'd2; h_head = EAST; h_sq = 4'd1; end
            8'h02: begin v_head = NORTH; v_sq = 4'd2; h_head = WEST; h_sq = 4'd1; end
            8'h04: begin v_head = NORTH; v_sq = 4'd1; h_head = WEST; h_sq = 4'd2; end
            8'h08: begin v_head = SOUTH; v_sq = 4'd1; h_head = WEST; h_sq = 4'd2; end
            8'h10: begin v_head = SOUTH; v_sq = 4'd2; h_head = WEST; h_sq = 4'd1; end
            8'h20: begin v_head = SOUTH; v_sq = 4'd2; h_head = EAST; h_sq = 4'd1; end
            8'h40: begin v_head = SOUTH; v_sq = 4'd1; h_head = EAST; h_sq = 4'd2; end
            8'h80: begin v_head = NORTH; v_sq = 4'd1; h_head = EAST; h_sq = 4'd2; end
            default: ;
        endcase
    end

    // Output logic
    always_comb begin
        cmd              = cmd_UART;
        cmd_rdy          = 1'b0;
        clr_cmd_rdy_UART = 1'b0;
        resp             = 8'hA5;
        case (state)
            IDLE: begin
                cmd              = cmd_UART;
                cmd_rdy          = cmd_rdy_UART;
                clr_cmd_rdy_UART = clr_cmd_rdy;
                resp             = 8'h5A;
            end
            VERT: begin
                cmd     = {OP_MOVE, v_head, v_sq};
                cmd_rdy = 1'b1;
            end
            HOLDV: begin
                cmd = {OP_MOVE, v_head, v_sq};
            end
            HORZ: begin
                cmd     = {OP_HORZ, h_head, h_sq};
                cmd_rdy = 1'b1;
            end
            HOLDH: begin
                cmd = {OP_HORZ, h_head, h_sq};
                if (last_move) resp = 8'h5A;
            end
            default: ;
        endcase
    end

    assign tour_busy = (state != IDLE);

endmodule

// File: tb/tb_tour_cmd_seq.sv
// Testbench for tour_cmd_seq: randomized tours checked against a move-table model.
// Solver read port is modelled as a combinational array lookup.
module tb_tour_cmd_seq;

    localparam int N = 24;

`ifdef TOUR_FANFARE_EN
    localparam logic [3:0] HOP = 4'b0011;
`else
    localparam logic [3:0] HOP = 4'b0010;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_tour = 1'b0;
    logic [7:0]  move;
    logic [4:0]  mv_indx;
    logic [15:0] cmd_UART = 16'h0000;
    logic        cmd_rdy_UART = 1'b0;
    logic        clr_cmd_rdy_UART;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy = 1'b0;
    logic        send_resp = 1'b0;
    logic [7:0]  resp;
    logic        tour_busy;

    logic [7:0]  moves [N];

    int tests = 0;
    int fails = 0;

    int dxt [8] = '{1, -1, -2, -2, -1, 1, 2, 2};
    int dyt [8] = '{2, 2, 1, -1, -2, -2, -1, 1};

    always #5 clk = ~clk;

    always_comb begin
        move = 8'h00;
        if (int'(mv_indx) < N) move = moves[mv_indx];
    end

    tour_cmd_seq #(.NUM_MOVES(N)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start_tour       (start_tour),
        .move             (move),
        .mv_indx          (mv_indx),
        .cmd_UART         (cmd_UART),
        .cmd_rdy_UART     (cmd_rdy_UART),
        .clr_cmd_rdy_UART (clr_cmd_rdy_UART),
        .cmd              (cmd),
        .cmd_rdy          (cmd_rdy),
        .clr_cmd_rdy      (clr_cmd_rdy),
        .send_resp        (send_resp),
        .resp             (resp),
        .tour_busy        (tour_busy)
    );

    // Reference: expected leg command from the (dx,dy) move table
    function automatic logic [15:0] exp_cmd(input logic [7:0] m, input bit horiz);
        int dx = 0;
        int dy = 0;
        int d;
        int mag;
        logic [7:0] head;
        if ($countones(m) == 1) begin
            for (int k = 0; k < 8; k++)
                if (m[k]) begin dx = dxt[k]; dy = dyt[k]; end
        end
        d = horiz ? dx : dy;
        mag = (d < 0) ? -d : d;
        if (horiz) head = (d > 0) ? 8'hBF : (d < 0) ? 8'h3F : 8'h00;
        else       head = (d < 0) ? 8'h7F : 8'h00;
        return {(horiz ? HOP : 4'b0010), head, 4'(mag)};
    endfunction

    function automatic logic [7:0] rand_move();
        if ($urandom_range(0, 9) == 0) return 8'($urandom);
        return 8'h01 << $urandom_range(0, 7);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic pulse_start();
        start_tour = 1'b1;
        tick();
        start_tour = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_cmd_rdy = 1'b1;
        tick();
        clr_cmd_rdy = 1'b0;
    endtask

    task automatic pulse_resp();
        send_resp = 1'b1;
        tick();
        send_resp = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cmd_rdy_UART = 1'b1;
        #2;
        tests++;
        if (tour_busy !== 1'b0 || mv_indx !== 5'd0) begin
            fails++;
            $display("FAIL reset_state busy=%b idx=%0d want 0/0", tour_busy, mv_indx);
        end
        tests++;
        if (cmd_rdy !== 1'b1 || resp !== 8'h5A) begin
            fails++;
            $display("FAIL reset_out rdy=%b resp=%h want 1/5a", cmd_rdy, resp);
        end
        cmd_rdy_UART = 1'b0;
        do_reset();
        tests++;
        if (cmd_rdy !== 1'b0) begin
            fails++;
            $display("FAIL reset_rdy0 rdy=%b want 0", cmd_rdy);
        end
    endtask

    task automatic test_passthrough();
        cmd_UART = 16'h2BF3;
        cmd_rdy_UART = 1'b1;
        #1;
        tests++;
        if (cmd !== 16'h2BF3 || cmd_rdy !== 1'b1) begin
            fails++;
            $display("FAIL pass_cmd cmd=%h rdy=%b want 2bf3/1", cmd, cmd_rdy);
        end
        tests++;
        if (clr_cmd_rdy_UART !== 1'b0) begin
            fails++;
            $display("FAIL pass_clr_idle got=%b want 0", clr_cmd_rdy_UART);
        end
        clr_cmd_rdy = 1'b1;
        #1;
        tests++;
        if (clr_cmd_rdy_UART !== 1'b1) begin
            fails++;
            $display("FAIL pass_clr got=%b want 1", clr_cmd_rdy_UART);
        end
        tick();
        clr_cmd_rdy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            logic [15:0] c;
            logic r;
            c = 16'($urandom);
            r = 1'($urandom);
            cmd_UART = c;
            cmd_rdy_UART = r;
            tick();
            tests++;
            if (cmd !== c || cmd_rdy !== r || tour_busy !== 1'b0) begin
                fails++;
                $display("FAIL pass_rand cmd=%h rdy=%b want %h/%b", cmd, cmd_rdy, c, r);
            end
        end
        cmd_rdy_UART = 1'b0;
    endtask

    task automatic test_single(input logic [7:0] m, input logic [15:0] v, input logic [15:0] h);
        moves[0] = m;
        pulse_start();
        tests++;
        if (cmd !== v || cmd_rdy !== 1'b1 || tour_busy !== 1'b1) begin
            fails++;
            $display("FAIL single_vert cmd=%h rdy=%b want %h/1", cmd, cmd_rdy, v);
        end
        pulse_clr();
        tests++;
        if (cmd_rdy !== 1'b0 || resp !== 8'hA5) begin
            fails++;
            $display("FAIL single_holdv rdy=%b resp=%h want 0/a5", cmd_rdy, resp);
        end
        pulse_resp();
        tests++;
        if (cmd !== h || cmd_rdy !== 1'b1) begin
            fails++;
            $display("FAIL single_horz cmd=%h rdy=%b want %h/1", cmd, cmd_rdy, h);
        end
        do_reset();
    endtask

    task automatic test_full_tour();
        int legs = 0;
        for (int i = 0; i < N; i++) moves[i] = rand_move();
        pulse_start();
        for (int leg = 0; leg < 2 * N; leg++) begin
            logic [15:0] e;
            e = exp_cmd(moves[leg / 2], leg % 2 == 1);
            for (int w = $urandom_range(0, 2); w >= 0; w--) begin
                start_tour = 1'($urandom);
                cmd_rdy_UART = 1'($urandom);
                send_resp = 1'($urandom);
                #1;
                tests++;
                if (cmd !== e || cmd_rdy !== 1'b1 || mv_indx !== 5'(leg / 2)) begin
                    fails++;
                    $display("FAIL tour_leg%0d cmd=%h rdy=%b idx=%0d want %h/1/%0d",
                             leg, cmd, cmd_rdy, mv_indx, e, leg / 2);
                end
                tests++;
                if (clr_cmd_rdy_UART !== 1'b0) begin
                    fails++;
                    $display("FAIL tour_uart_clr leg%0d got=%b want 0", leg, clr_cmd_rdy_UART);
                end
                if (w > 0) tick();
            end
            send_resp = 1'b0;
            start_tour = 1'b0;
            cmd_rdy_UART = 1'b0;
            pulse_clr();
            for (int w = $urandom_range(0, 2); w > 0; w--) begin
                clr_cmd_rdy = 1'($urandom);
                tick();
            end
            clr_cmd_rdy = 1'b0;
            send_resp = 1'b1;
            #1;
            tests++;
            if (cmd_rdy !== 1'b0 || tour_busy !== 1'b1 ||
                resp !== ((leg == 2 * N - 1) ? 8'h5A : 8'hA5)) begin
                fails++;
                $display("FAIL tour_resp leg%0d rdy=%b resp=%h", leg, cmd_rdy, resp);
            end
            tick();
            send_resp = 1'b0;
            legs++;
        end
        tests++;
        if (legs != 2 * N || tour_busy !== 1'b0 || resp !== 8'h5A) begin
            fails++;
            $display("FAIL tour_end busy=%b resp=%h want 0/5a", tour_busy, resp);
        end
    endtask

    task automatic test_protocol();
        moves[0] = 8'h40;
        moves[1] = 8'h02;
        pulse_start();
        send_resp = 1'b1;
        tick();
        send_resp = 1'b0;
        tests++;
        if (cmd !== 16'h27F1 || cmd_rdy !== 1'b1) begin
            fails++;
            $display("FAIL proto_resp_in_vert cmd=%h rdy=%b want 27f1/1", cmd, cmd_rdy);
        end
        clr_cmd_rdy = 1'b1;
        send_resp = 1'b1;
        tick();
        clr_cmd_rdy = 1'b0;
        send_resp = 1'b0;
        tests++;
        if (cmd_rdy !== 1'b0 || tour_busy !== 1'b1) begin
            fails++;
            $display("FAIL proto_both rdy=%b busy=%b want 0/1", cmd_rdy, tour_busy);
        end
        pulse_clr();
        tests++;
        if (cmd_rdy !== 1'b0) begin
            fails++;
            $display("FAIL proto_clr_in_hold rdy=%b want 0", cmd_rdy);
        end
        pulse_resp();
        tests++;
        if (cmd !== {HOP, 8'hBF, 4'd2} || cmd_rdy !== 1'b1) begin
            fails++;
            $display("FAIL proto_horz cmd=%h rdy=%b want %h/1", cmd, cmd_rdy, {HOP, 8'hBF, 4'd2});
        end
        do_reset();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < N; i++) moves[i] = rand_move();
        pulse_start();
        for (int i = 0; i < 10; i++) begin
            pulse_clr();
            pulse_resp();
            pulse_clr();
            pulse_resp();
        end
        pulse_clr();
        tests++;
        if (mv_indx !== 5'd10 || cmd_rdy !== 1'b0 || tour_busy !== 1'b1) begin
            fails++;
            $display("FAIL mid_setup idx=%0d rdy=%b want 10/0", mv_indx, cmd_rdy);
        end
        cmd_UART = 16'h1234;
        cmd_rdy_UART = 1'b1;
        rst_n = 1'b0;
        #1;
        tests++;
        if (tour_busy !== 1'b0 || mv_indx !== 5'd0 || cmd !== 16'h1234 || cmd_rdy !== 1'b1) begin
            fails++;
            $display("FAIL mid_reset busy=%b idx=%0d cmd=%h rdy=%b want 0/0/1234/1",
                     tour_busy, mv_indx, cmd, cmd_rdy);
        end
        tick();
        rst_n = 1'b1;
        tick();
        tests++;
        if (tour_busy !== 1'b0 || cmd !== 16'h1234 || resp !== 8'h5A) begin
            fails++;
            $display("FAIL mid_after busy=%b cmd=%h resp=%h", tour_busy, cmd, resp);
        end
        cmd_rdy_UART = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) moves[i] = 8'h00;
        test_reset();
        test_passthrough();
        test_single(8'h01, 16'h2002, {HOP, 8'hBF, 4'd1});
        test_single(8'h08, 16'h27F1, {HOP, 8'h3F, 4'd2});
        test_single(8'h10, 16'h27F2, {HOP, 8'h3F, 4'd1});
        test_single(8'h80, 16'h2001, {HOP, 8'hBF, 4'd2});
        test_single(8'h03, 16'h2000, {HOP, 8'h00, 4'd0});
        test_full_tour();
        test_full_tour();
        do_reset();
        test_protocol();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tour_cmd_seq.md
# tour_cmd_seq

Downstream consumer of the knight's-tour solver. When the solver pulses its done strobe, this block walks the 24 stored one-hot moves through the solver's index/move read port. It converts each move into two motion commands: a vertical leg, then a horizontal leg. Outside a tour it passes UART-sourced commands straight through to the command processor, so it sits between the UART wrapper, the tour solver and the command processor.

## Interface
Parameters:
- NUM_MOVES, 24, number of moves replayed per tour (index 0..NUM_MOVES-1)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- start_tour  in  1  one-cycle solver done pulse; begins replay
- move  in  8  one-hot move read from solver at mv_indx (combinational from solver)
- mv_indx  out  5  index presented to solver read port
- cmd_UART  in  16  command from UART wrapper
- cmd_rdy_UART  in  1  UART command valid
- clr_cmd_rdy_UART  out  1  consume strobe back to UART wrapper
- cmd  out  16  command to command processor
- cmd_rdy  out  1  cmd valid
- clr_cmd_rdy  in  1  command processor has accepted cmd
- send_resp  in  1  command processor finished executing cmd
- resp  out  8  response byte for UART transmitter
- tour_busy  out  1  high while replaying

## Operation
**Move decode.** Bit k of move gives (dx,dy):
- 0 = (+1,+2)
- 1 = (−1,+2)
- 2 = (−2,+1)
- 3 = (−2,−1)
- 4 = (−1,−2)
- 5 = (+1,−2)
- 6 = (+2,−1)
- 7 = (+2,+1)

A non-one-hot move decodes as (0,0). The leg is still issued, with 0 squares.

**Command format.** cmd = {opcode[3:0], heading[7:0], squares[3:0]}.
- Opcodes: move = 4'b0010, move+fanfare = 4'b0011.
- Headings: north 8'h00, west 8'h3F, south 8'h7F, east 8'hBF.
- Vertical leg: dy>0 → north, dy<0 → south; squares = |dy|; opcode 4'b0010.
- Horizontal leg: dx>0 → east, dx<0 → west; squares = |dx|; opcode per Configuration.

**State machine.** States are IDLE, VERT, HOLDV, HORZ, HOLDH.
- IDLE: passthrough. cmd=cmd_UART, cmd_rdy=cmd_rdy_UART, clr_cmd_rdy_UART=clr_cmd_rdy. On start_tour: mv_indx←0, go to VERT.
- VERT: cmd=vertical leg, cmd_rdy=1. On clr_cmd_rdy go to HOLDV.
- HOLDV: cmd_rdy=0. On send_resp go to HORZ.
- HORZ: cmd=horizontal leg, cmd_rdy=1. On clr_cmd_rdy go to HOLDH.
- HOLDH: cmd_rdy=0. On send_resp:
  - if mv_indx==NUM_MOVES−1, go to IDLE;
  - otherwise mv_indx←mv_indx+1, go to VERT.
- clr_cmd_rdy_UART is 0 in every non-IDLE state; UART commands arriving mid-tour stay pending upstream.
- tour_busy = (state != IDLE).

**Responses.**
- resp = 8'h5A in IDLE.
- In tour states: resp = 8'h5A when in HOLDH with mv_indx==NUM_MOVES−1; else 8'hA5.
- This gives the host 8'hA5 per intermediate leg and 8'h5A on tour completion.

**Boundary conditions.**
- start_tour outside IDLE is ignored.
- clr_cmd_rdy and send_resp in the same cycle while in VERT/HORZ: only clr_cmd_rdy is acted on; send_resp is ignored.
- send_resp in VERT/HORZ is ignored.
- clr_cmd_rdy in HOLDV/HOLDH is ignored.
- mv_indx is 5 bits and never exceeds NUM_MOVES−1; no wrap.

## Timing
- Reset values: state IDLE, mv_indx 0, tour_busy 0, cmd_rdy = cmd_rdy_UART (combinational passthrough), resp 8'h5A.
- cmd, cmd_rdy, resp and clr_cmd_rdy_UART are combinational from state and inputs.
- mv_indx and state are registered.
- start_tour at edge N puts VERT on the outputs in cycle N+1, with cmd_rdy=1 and cmd for move[0].
- cmd_rdy drops the cycle after the clr_cmd_rdy edge.
- The next leg's cmd_rdy rises the cycle after the send_resp edge.
- move must be stable one cycle after mv_indx changes; the solver read is combinational.
- Reset asserted mid-tour immediately returns the block to IDLE passthrough with mv_indx=0. No partial commands are replayed.

## Configuration
Macro: TOUR_FANFARE_EN.
- Defined: horizontal legs use opcode 4'b0011, so the processor plays fanfare on landing each square.
- Undefined: horizontal legs use 4'b0010.
- Vertical legs and passthrough are unaffected either way.

## Test plan
- Passthrough: in IDLE, cmd_UART=16'h2BF3 with cmd_rdy_UART=1 gives cmd=16'h2BF3 and cmd_rdy=1; a clr_cmd_rdy pulse gives a clr_cmd_rdy_UART pulse in the same cycle.
- Single decode: start_tour with move[0]=8'h01 gives VERT cmd=16'h2002; after clr and send_resp, HORZ cmd=16'h3BF1 (FANFARE_EN) or 16'h2BF1 (undefined).
- Negative move: move=8'h08 gives 16'h27F1 (south, 1 square), then 16'h33F2 (west, 2 squares, fanfare).
- Full tour: 24 moves with clr/send_resp handshakes give 48 commands, then a return to IDLE and tour_busy=0; resp is 8'hA5 on the first 47 send_resp cycles and 8'h5A on the 48th.
- Protocol robustness: start_tour and cmd_rdy_UART pulsed mid-tour change nothing; clr_cmd_rdy together with send_resp in VERT advances only to HOLDV.
- Reset at mv_indx=10 in HOLDV gives IDLE, mv_indx=0, passthrough restored next cycle.
